id_decode_stage: RTL
====================

# id_decode_stage

Registered instruction-decode stage for the RISC-V pipeline, parametrised in XLEN (RV32I/RV64I). It sits between the IF/ID boundary and the register-file read / hazard logic. It accepts one fetched instruction per valid/ready transfer and holds decoded fields, immediate, format class and legality in an output register. It supports backpressure and flush.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64. Immediates are sign-extended to XLEN. RV64-only opcodes/funct3 are legal only when XLEN=64.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held and incoming instruction (branch redirect / trap)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded entry held
- out_ready  in  1  downstream accepts entry
- out_pc  out  XLEN  PC of held entry
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices (0 when unused by format)
- out_funct3  out  3; out_funct7  out  7  (0 when unused by format)
- out_imm  out  XLEN  sign-extended immediate per format; 0 for R-type/illegal
- out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=ILLEGAL
- out_uses_rs1, out_uses_rs2, out_writes_rd  out  1 each  operand/writeback flags; writes_rd=0 when rd==0
- out_illegal  out  1  undecodable instruction; all fields except out_pc/out_opcode forced 0

## Operation
- Single-entry pipeline register, states EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- EMPTY→FULL on accept. FULL→FULL on accept with out_ready (back-to-back). FULL→EMPTY on out_ready && !in_valid.
- FULL && !out_ready: every output is held bit-stable.
- flush has priority: next cycle out_valid=0. Any same-cycle accept is discarded. in_ready is not gated by flush.
- Legality:
  - instr[1:0]!=2'b11 is illegal. Unknown opcode is illegal.
  - JALR needs funct3=000. BRANCH funct3 010/011 is illegal.
  - LOAD funct3 111 is illegal. LOAD funct3 011/110 is legal only for XLEN=64.
  - STORE funct3 >011 is illegal. STORE 011 is legal only for XLEN=64.
  - OP needs funct7 0000000, or 0100000 only with funct3 000/101.
  - OP-IMM shifts: funct7 (XLEN=32) or instr[31:26] (XLEN=64) must be 0, or 0100000/010000 for SRAI.
  - OP-IMM-32 (0011011) and OP-32 (0111011) are legal only for XLEN=64.
  - MISC-MEM (0001111) and SYSTEM (1110011) decode as I-type.
- Immediate rules:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}, sign-extended to XLEN for XLEN=64.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - All immediates are sign-extended from their top bit to XLEN.

## Timing
- Latency is 1 cycle from accept to out_valid, with 1 instruction/cycle sustained throughput.
- Reset: out_valid=0 and all out_* = 0. out_fmt=0 while empty. in_ready=1 the cycle after reset deasserts.
- Reset mid-operation drops the held entry. No partial state survives.
- Decode is purely from in_instr at accept. No multi-cycle decode.

## Structure
- Shared header rv_defs.vh holds the opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM, OP_IMM_32, OP_32) and the FMT_* codes.
- Sub-module rv_field_decode: combinational, parameter XLEN. Maps instr to fields, imm, fmt, flags and illegal. The stage registers its outputs and owns the handshake.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → next cycle: out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, fmt=1, uses_rs1=1, writes_rd=1, illegal=0.
- 0x0020A423 (sw x2,8(x1)) then 0xFE000EE3 (beq x0,x0,-4) back-to-back with out_ready=1:
  - first: imm=8, rs1=1, rs2=2, fmt=2, writes_rd=0.
  - second: imm=0xFFFFFFFC, fmt=3.
- 0x00033283 (ld x5,0(x6)):
  - XLEN=32 → illegal=1, fmt=7, rd=0.
  - XLEN=64 → legal, rd=5, rs1=6, imm=0.
- 0x00000000 and 0x00000013 with out_ready=1:
  - first: illegal=1, fields 0.
  - second (nop): legal, writes_rd=0.
- Backpressure: out_ready=0 for 5 cycles while FULL with in_valid=1 → in_ready=0, outputs stable. Release → held entry drains, then the new instruction appears next cycle.
- flush asserted together with an accept while FULL → out_valid=0 next cycle, and neither entry appears. rst mid-stream → all outputs 0.

Source files
------------

// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the instruction-decode stage: RISC-V base opcodes,
// format class codes, the stage FSM states and the decoded-field bundle.
package id_decode_stage_pkg;

  // Base opcodes (instr[6:0]) understood by the decoder
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // funct7 value selecting SUB/SRA/SRAI
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

  // Instruction format class as presented on out_fmt
  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  // Occupancy of the single-entry output register
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stageState_e;

  // Everything the decoder produces except the XLEN-wide immediate
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       usesRs1;
    logic       usesRs2;
    logic       writesRd;
    logic       illegal;
  } decFields_t;

  // Format class implied by the opcode alone; legality is judged separately
  function automatic fmt_e formatOf(input logic [6:0] opcode);
    fmt_e result;
    case (opcode)
      OPC_OP, OPC_OP_32:                        result = FMT_R;
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD,
      OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:       result = FMT_I;
      OPC_STORE:                                result = FMT_S;
      OPC_BRANCH:                               result = FMT_B;
      OPC_LUI, OPC_AUIPC:                       result = FMT_U;
      OPC_JAL:                                  result = FMT_J;
      default:                                  result = FMT_ILLEGAL;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/id_decode_stage_field_decode.sv
// Purely combinational field extraction for one 32-bit instruction word:
// register indices, funct fields, sign-extended immediate, format class,
// operand/writeback flags and legality for the configured XLEN.
module rv_field_decode
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output decFields_t      fields_o,
  output logic [XLEN-1:0] imm_o
);

  localparam logic IS_RV64 = (XLEN == 64);

  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  fmt_e               baseFmt;
  logic               legal;
  logic               shamtHiZero;
  logic               shamtHiSra;
  logic signed [31:0] imm32;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign funct3  = instr_i[14:12];
  assign rs1     = instr_i[19:15];
  assign rs2     = instr_i[24:20];
  assign funct7  = instr_i[31:25];
  assign baseFmt = formatOf(opcode);

  // RV64 shift amounts are 6 bits wide, so only instr[31:26] must be clear
  assign shamtHiZero = IS_RV64 ? (instr_i[31:26] == 6'b000000) : (funct7 == 7'b0000000);
  assign shamtHiSra  = IS_RV64 ? (instr_i[31:26] == 6'b010000) : (funct7 == FUNCT7_ALT);

  // Judge whether the word is a legal base-ISA instruction for this XLEN
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_MISC_MEM, OPC_SYSTEM:    legal = 1'b1;
      OPC_JALR:                    legal = (funct3 == 3'b000);
      OPC_BRANCH:                  legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OPC_LOAD: begin
        case (funct3)
          3'b111:         legal = 1'b0;
          3'b011, 3'b110: legal = IS_RV64;
          default:        legal = 1'b1;
        endcase
      end
      OPC_STORE:                   legal = (funct3 < 3'b011) || ((funct3 == 3'b011) && IS_RV64);
      OPC_OP:                      legal = (funct7 == 7'b0000000) ||
                                           ((funct7 == FUNCT7_ALT) &&
                                            ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = shamtHiZero;
          3'b101:  legal = shamtHiZero || shamtHiSra;
          default: legal = 1'b1;
        endcase
      end
      OPC_OP_IMM_32, OPC_OP_32:    legal = IS_RV64;
      default:                     legal = 1'b0;
    endcase
    if (instr_i[1:0] != 2'b11) begin
      legal = 1'b0;
    end
  end

  // Populate only the fields the format actually carries; illegal words keep just the opcode
  always_comb begin
    fields_o        = '0;
    imm32           = '0;
    fields_o.opcode = opcode;
    if (!legal) begin
      fields_o.fmt     = FMT_ILLEGAL;
      fields_o.illegal = 1'b1;
    end else begin
      fields_o.fmt = baseFmt;
      case (baseFmt)
        FMT_R: begin
          fields_o.rd       = rd;
          fields_o.rs1      = rs1;
          fields_o.rs2      = rs2;
          fields_o.funct3   = funct3;
          fields_o.funct7   = funct7;
          fields_o.usesRs1  = 1'b1;
          fields_o.usesRs2  = 1'b1;
          fields_o.writesRd = (rd != 5'd0);
        end
        FMT_I: begin
          fields_o.rd       = rd;
          fields_o.rs1      = rs1;
          fields_o.funct3   = funct3;
          fields_o.usesRs1  = 1'b1;
          fields_o.writesRd = (rd != 5'd0);
          imm32             = {{20{instr_i[31]}}, instr_i[31:20]};
        end
        FMT_S: begin
          fields_o.rs1     = rs1;
          fields_o.rs2     = rs2;
          fields_o.funct3  = funct3;
          fields_o.usesRs1 = 1'b1;
          fields_o.usesRs2 = 1'b1;
          imm32            = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
        FMT_B: begin
          fields_o.rs1     = rs1;
          fields_o.rs2     = rs2;
          fields_o.funct3  = funct3;
          fields_o.usesRs1 = 1'b1;
          fields_o.usesRs2 = 1'b1;
          imm32            = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
        end
        FMT_U: begin
          fields_o.rd       = rd;
          fields_o.writesRd = (rd != 5'd0);
          imm32             = {instr_i[31:12], 12'b0};
        end
        FMT_J: begin
          fields_o.rd       = rd;
          fields_o.writesRd = (rd != 5'd0);
          imm32             = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
        end
        default: begin
          fields_o.fmt     = FMT_ILLEGAL;
          fields_o.illegal = 1'b1;
        end
      endcase
    end
  end

  // Every immediate fits in 32 bits; widening the signed value sign-extends it to XLEN
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/id_decode_stage.sv
// Registered instruction-decode stage: a single-entry output register with a
// valid/ready handshake, backpressure and flush. Decoding itself is done
// combinationally on the incoming word by rv_field_decode.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd,
  output logic            out_illegal
);

  stageState_e     state_q;
  decFields_t      fields_q;
  decFields_t      fields_d;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] pc_q;
  logic            accept;

  rv_field_decode #(
    .XLEN(XLEN)
  ) u_fieldDecode (
    .instr_i  (in_instr),
    .fields_o (fields_d),
    .imm_o    (imm_d)
  );

  // A slot is free when empty or when the held entry leaves this cycle; flush does not gate it
  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // Occupancy FSM and output register; an empty stage always shows all-zero outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      fields_q <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else if (flush) begin
      state_q  <= EMPTY;
      fields_q <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q  <= FULL;
            fields_q <= fields_d;
            imm_q    <= imm_d;
            pc_q     <= in_pc;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              state_q  <= FULL;
              fields_q <= fields_d;
              imm_q    <= imm_d;
              pc_q     <= in_pc;
            end else begin
              state_q  <= EMPTY;
              fields_q <= '0;
              imm_q    <= '0;
              pc_q     <= '0;
            end
          end
        end
        default: begin
          state_q  <= EMPTY;
          fields_q <= '0;
          imm_q    <= '0;
          pc_q     <= '0;
        end
      endcase
    end
  end

  assign out_valid     = (state_q == FULL);
  assign out_pc        = pc_q;
  assign out_opcode    = fields_q.opcode;
  assign out_rd        = fields_q.rd;
  assign out_rs1       = fields_q.rs1;
  assign out_rs2       = fields_q.rs2;
  assign out_funct3    = fields_q.funct3;
  assign out_funct7    = fields_q.funct7;
  assign out_imm       = imm_q;
  assign out_fmt       = fields_q.fmt;
  assign out_uses_rs1  = fields_q.usesRs1;
  assign out_uses_rs2  = fields_q.usesRs2;
  assign out_writes_rd = fields_q.writesRd;
  assign out_illegal   = fields_q.illegal;

endmodule
